tone_sample_source: RTL
=======================

# tone_sample_source

Phase-accumulator tone generator that sources 24-bit stereo samples for the audio CODEC's DAC path. It sits directly upstream of the `audio_codec` write port, and drives `write`, `writedata_left` and `writedata_right` under the `write_ready` handshake. Pitch, waveform and volume come from the synthesizer's key/note logic. Sample rate is paced entirely by the CODEC: one accepted write is one 48 kHz output sample.

## Interface
- `PHASE_W`, default 24: phase accumulator width; must be ≥ 24.
- `CNT_W`, default 16: width of `sample_count`.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  run request; low parks the block in IDLE.
- `wave_sel`  in  2  waveform: 00 square, 01 saw, 10 triangle, 11 silence.
- `tuning_word`  in  PHASE_W  phase increment per sample; f = tw·48000/2^PHASE_W.
- `volume`  in  3  attenuation, arithmetic right shift 0..7.
- `write_ready`  in  1  CODEC DAC FIFO has room.
- `write`  out  1  one-cycle write strobe to the CODEC.
- `writedata_left`  out  24  two's-complement sample.
- `writedata_right`  out  24  identical to left.
- `sample_count`  out  CNT_W  accepted writes, mod 2^CNT_W.

## Operation
- State machine states: IDLE, CALC, WAIT, WRITE. All outputs are registered.
- IDLE: `write`=0 and data=0. When `enable`=1, go to CALC.
- CALC, one cycle:
  - Snapshot `wave_sel`, `tuning_word` and `volume`.
  - Compute the sample from the current phase and load `writedata_*`.
  - Go to WAIT if `enable`=1, otherwise go to IDLE.
- WAIT:
  - Hold the data stable.
  - If `enable`=0, go to IDLE with no write and phase unchanged.
  - Else if `write_ready`=1, go to WRITE.
- WRITE, one cycle:
  - `write`=1.
  - phase ← phase + snapshot tw, mod 2^PHASE_W (wraps silently).
  - `sample_count` +1, wrapping.
  - Then go to CALC if `enable`=1, else IDLE. `enable` does not abort WRITE.
- Waveform math uses p = phase[PHASE_W-1 -: 24]:
  - Square: p[23]=0 gives 0x7FFFFF; p[23]=1 gives 0x800000.
  - Saw: p XOR 0x800000.
  - Triangle:
    - t = p[22:0] when p[23]=0, else ~p[22:0].
    - Sample = {t,1'b0} XOR 0x800000.
  - Silence: 0x000000. Writes still occur so the CODEC FIFO stays fed.
  - The result is then shifted right arithmetically (`>>>`) by `volume`, sign-extended within 24 bits.
- Phase is retained across IDLE; only `reset` clears it.
- Input changes between CALC cycles do not affect the sample currently pending.

## Timing
- Reset is asynchronous: state=IDLE, phase=0, `write`=0, `writedata_*`=0, `sample_count`=0, applied immediately on assertion.
  - Reset mid-WRITE kills the strobe in the same cycle.
- Latency with `write_ready` already high: `enable` sampled high in IDLE → CALC → WAIT → `write` high on the 3rd rising edge.
- Steady state with `write_ready`=1: one write every 3 cycles (WRITE→CALC→WAIT→WRITE).
- `write` is never high for two consecutive cycles.
- `write_ready` is sampled only in WAIT. A drop of `write_ready` during WRITE does not cancel the accepted write.
- `write_ready` low indefinitely: the block stays in WAIT with data stable, `write`=0.
- `enable` low and `write_ready` high in the same WAIT cycle: `enable` wins, no write.

## Test plan
- Reset: assert `reset` mid-run → same cycle `write`=0, data=0x000000, `sample_count`=0. After release with `enable`=1 and `write_ready`=1 → first write on the 3rd edge, phase restarted from 0.
- Square: tw=0x200000, volume 0, `write_ready`=1 → write every 3 cycles; data 0x7FFFFF ×4, then 0x800000 ×4, repeating; left==right.
- Saw: tw=0x400000 → 0x800000, 0xC00000, 0x000000, 0x400000, repeat. Triangle, same tw → 0x800000, 0x000000, 0x7FFFFE, 0xFFFFFE.
- Volume: square, volume=3 → 0x0FFFFF, then 0xF00000. wave_sel=11 → 0x000000 with writes continuing.
- Handshake: hold `write_ready`=0 for 10 cycles → state WAIT, no strobe, data constant. Raise `write_ready` → exactly one 1-cycle `write` on the next edge, `sample_count` +1.
- Abort and wrap:
  - Drop `enable` in WAIT → IDLE, no write, `sample_count` unchanged.
  - Resume → same sample value is produced.
  - Preload 0xFFFF writes → next write wraps `sample_count` to 0x0000.

Source files
------------

// File: rtl/tone_sample_source.sv
// Phase-accumulator tone source feeding the CODEC DAC write port.
// One accepted write per generated sample; the pace comes from write_ready.
module tone_sample_source #(
  parameter int PHASE_W = 24,
  parameter int CNT_W   = 16
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] tuning_word,
  input  logic [2:0]         volume,
  input  logic               write_ready,
  output logic               write,
  output logic [23:0]        writedata_left,
  output logic [23:0]        writedata_right,
  output logic [CNT_W-1:0]   sample_count
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic               write_q, write_d;
  logic [23:0]        data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [23:0]        p;
  logic [22:0]        tri_t;
  logic [23:0]        raw;
  logic signed [23:0] shaped;

  // Waveform shaping from the top 24 phase bits, then volume attenuation.
  always_comb begin
    p     = phase_q[PHASE_W-1 -: 24];
    tri_t = p[23] ? ~p[22:0] : p[22:0];
    case (wave_sel)
      2'b00:   raw = p[23] ? 24'h800000 : 24'h7FFFFF;
      2'b01:   raw = p ^ 24'h800000;
      2'b10:   raw = {tri_t, 1'b0} ^ 24'h800000;
      default: raw = 24'h000000;
    endcase
    shaped = $signed(raw) >>> volume;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      tw_q    <= '0;
      write_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      tw_q    <= tw_d;
      write_q <= write_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_CALC;
      S_CALC:  state_d = enable ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (!enable)          state_d = S_IDLE;
        else if (write_ready) state_d = S_WRITE;
      end
      S_WRITE: state_d = enable ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The strobe, phase step and count all land on the edge that enters WRITE,
  // so the count seen alongside the strobe already includes that write.
  always_comb begin
    phase_d = phase_q;
    tw_d    = tw_q;
    write_d = 1'b0;
    data_d  = data_q;
    count_d = count_q;
    if (state_q == S_CALC) begin
      data_d = shaped;
      tw_d   = tuning_word;
    end
    if (state_q == S_WAIT && enable && write_ready) begin
      write_d = 1'b1;
      phase_d = phase_q + tw_q;
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (state_d == S_IDLE) data_d = '0;
  end

  assign write           = write_q;
  assign writedata_left  = data_q;
  assign writedata_right = data_q;
  assign sample_count    = count_q;

endmodule
